// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-side signals for the sequencing controller.
//   EX/WB inputs : branchNout, branchZout, Nout, Zout, jumpOut, jumpMemout
//   ID inputs    : idValid, idRs, idRt, idUsesRs, idUsesRt, idRegWrt, idRd
//   Controls out : pcSel, pcWrite, ifidWrite, ifidFlush, idexFlush, exwbHold
//   Statistics   : flushCount (saturating redirect count)
// master = the pipeline datapath side, slave = the controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned FLUSH_CNT_W = 16
);
  logic                   branchNout;
  logic                   branchZout;
  logic                   Nout;
  logic                   Zout;
  logic                   jumpOut;
  logic                   jumpMemout;
  logic                   idValid;
  logic [5:0]             idRs;
  logic [5:0]             idRt;
  logic                   idUsesRs;
  logic                   idUsesRt;
  logic                   idRegWrt;
  logic [5:0]             idRd;
  logic [1:0]             pcSel;
  logic                   pcWrite;
  logic                   ifidWrite;
  logic                   ifidFlush;
  logic                   idexFlush;
  logic                   exwbHold;
  logic [FLUSH_CNT_W-1:0] flushCount;

  modport master (
    output branchNout, branchZout, Nout, Zout, jumpOut, jumpMemout,
    output idValid, idRs, idRt, idUsesRs, idUsesRt, idRegWrt, idRd,
    input  pcSel, pcWrite, ifidWrite, ifidFlush, idexFlush, exwbHold,
    input  flushCount
  );

  modport slave (
    input  branchNout, branchZout, Nout, Zout, jumpOut, jumpMemout,
    input  idValid, idRs, idRt, idUsesRs, idUsesRt, idRegWrt, idRd,
    output pcSel, pcWrite, ifidWrite, ifidFlush, idexFlush, exwbHold,
    output flushCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 4-stage IF/ID/EX/WB pipeline.
// Resolves control transfers at EX/WB, selects the next-PC source, and
// stalls decode on RAW hazards against a scoreboard of in-flight writes
// (no forwarding).
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : pipe_hazard_ctrl_if.slave (EX/WB + ID inputs, pipeline controls,
//           saturating redirect counter)
// pcSel: 00 = PC+1, 01 = register target, 10 = dataMemout.
module pipe_hazard_ctrl #(
  parameter int unsigned SB_DEPTH    = 2,
  parameter int unsigned RF_BYPASS   = 1,
  parameter int unsigned JM_LAT      = 1,
  parameter int unsigned FLUSH_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_hazard_ctrl_if.slave     bus
);

  // With a write-first register file the oldest (EX/WB) entry cannot hazard.
  localparam int unsigned CHECK_DEPTH = (RF_BYPASS != 0) ? SB_DEPTH - 1 : SB_DEPTH;

  typedef enum logic {
    RUN,
    JM_WAIT
  } state_t;

  state_t                         state, state_nxt;
  logic [2:0]                     jm_cnt, jm_cnt_nxt;
  logic [SB_DEPTH-1:0]            sb_valid;
  logic [SB_DEPTH-1:0][5:0]       sb_rd;
  logic [FLUSH_CNT_W-1:0]         flush_cnt;

  logic                           taken;
  logic                           hazard;
  logic                           redirect;
  logic                           stall;
  logic                           hold;
  logic [1:0]                     pc_sel;
  logic                           pc_write;
  logic                           ifid_write;
  logic                           ifid_flush;
  logic                           idex_flush;

  assign taken = bus.jumpMemout | bus.jumpOut |
                 (bus.branchZout & bus.Zout) | (bus.branchNout & bus.Nout);

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < CHECK_DEPTH; i++) begin
      if (sb_valid[i] &&
          ((bus.idUsesRs && (bus.idRs == sb_rd[i])) ||
           (bus.idUsesRt && (bus.idRt == sb_rd[i])))) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard & bus.idValid;
  end

  // Decide the cycle's action first, then derive the pin values from it so
  // a redirect always dominates a stall.
  always_comb begin
    state_nxt  = state;
    jm_cnt_nxt = jm_cnt;
    redirect   = 1'b0;
    stall      = 1'b0;
    hold       = 1'b0;
    pc_sel     = 2'b00;
    case (state)
      RUN: begin
        if (bus.jumpMemout) begin
          if (JM_LAT == 0) begin
            redirect = 1'b1;
            pc_sel   = 2'b10;
          end else begin
            hold       = 1'b1;
            state_nxt  = JM_WAIT;
            jm_cnt_nxt = 3'(JM_LAT);
          end
        end else if (taken) begin
          redirect = 1'b1;
          pc_sel   = 2'b01;
        end else if (hazard) begin
          stall = 1'b1;
        end
      end
      JM_WAIT: begin
        if (jm_cnt == 3'd1) begin
          redirect  = 1'b1;
          pc_sel    = 2'b10;
          state_nxt = RUN;
        end else begin
          hold       = 1'b1;
          jm_cnt_nxt = jm_cnt - 3'd1;
        end
      end
      default: state_nxt = RUN;
    endcase

    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
    if (hold || stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
    if (stall) begin
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      jm_cnt <= '0;
    end else begin
      state  <= state_nxt;
      jm_cnt <= jm_cnt_nxt;
    end
  end

  // Redirect squashes everything younger and the EX/WB write retires anyway,
  // so the whole scoreboard clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid <= '0;
      sb_rd    <= '0;
    end else if (redirect) begin
      sb_valid <= '0;
    end else if (!hold) begin
      for (int unsigned i = 1; i < SB_DEPTH; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_rd[i]    <= sb_rd[i-1];
      end
      sb_valid[0] <= bus.idValid & bus.idRegWrt & ~stall;
      sb_rd[0]    <= bus.idRd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (redirect && (flush_cnt != '1)) begin
      flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
    end
  end

  assign bus.pcSel      = pc_sel;
  assign bus.pcWrite    = pc_write;
  assign bus.ifidWrite  = ifid_write;
  assign bus.ifidFlush  = ifid_flush;
  assign bus.idexFlush  = idex_flush;
  assign bus.exwbHold   = hold;
  assign bus.flushCount = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations driven with identical
// stimulus, each compared every cycle against a behavioural model.
//   dut0: SB_DEPTH=2, RF_BYPASS=1, JM_LAT=2
//   dut1: SB_DEPTH=2, RF_BYPASS=0, JM_LAT=0
module tb_pipe_hazard_ctrl;

  localparam int DEPTH = 2;
  localparam int BYP [2] = '{1, 0};
  localparam int LAT [2] = '{2, 0};
  localparam logic [22:0] RST_OUTS = {2'b00, 1'b1, 1'b1, 3'b000, 16'h0000};
  localparam int K_NORM = 0, K_STALL = 1, K_HOLD = 2, K_REDIR = 3;

  typedef struct packed {
    logic       branchNout, branchZout, Nout, Zout, jumpOut, jumpMemout, idValid;
    logic [5:0] idRs, idRt;
    logic       idUsesRs, idUsesRt, idRegWrt;
    logic [5:0] idRd;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst_n;
  stim_t st;

  int n_cmp = 0;
  int n_bad = 0;

  logic [22:0] obs [2];

  // model state
  bit          m_v  [2][DEPTH];
  logic [5:0]  m_rd [2][DEPTH];
  int          m_jm [2];
  int          m_cnt[2];

  pipe_hazard_ctrl_if #(.FLUSH_CNT_W(16)) bus0 ();
  pipe_hazard_ctrl_if #(.FLUSH_CNT_W(16)) bus1 ();

  assign {bus0.branchNout, bus0.branchZout, bus0.Nout, bus0.Zout, bus0.jumpOut,
          bus0.jumpMemout, bus0.idValid, bus0.idRs, bus0.idRt, bus0.idUsesRs,
          bus0.idUsesRt, bus0.idRegWrt, bus0.idRd} = st;
  assign {bus1.branchNout, bus1.branchZout, bus1.Nout, bus1.Zout, bus1.jumpOut,
          bus1.jumpMemout, bus1.idValid, bus1.idRs, bus1.idRt, bus1.idUsesRs,
          bus1.idUsesRt, bus1.idRegWrt, bus1.idRd} = st;

  pipe_hazard_ctrl #(.SB_DEPTH(2), .RF_BYPASS(1), .JM_LAT(2), .FLUSH_CNT_W(16))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pipe_hazard_ctrl #(.SB_DEPTH(2), .RF_BYPASS(0), .JM_LAT(0), .FLUSH_CNT_W(16))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] outs(input int d);
    if (d == 0)
      return {bus0.pcSel, bus0.pcWrite, bus0.ifidWrite, bus0.ifidFlush,
              bus0.idexFlush, bus0.exwbHold, bus0.flushCount};
    return {bus1.pcSel, bus1.pcWrite, bus1.ifidWrite, bus1.ifidFlush,
            bus1.idexFlush, bus1.exwbHold, bus1.flushCount};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_jm[d]  = 0;
      m_cnt[d] = 0;
      for (int k = 0; k < DEPTH; k++) begin
        m_v[d][k]  = 1'b0;
        m_rd[d][k] = '0;
      end
    end
  endtask

  // Expected outputs for this cycle from the current inputs, then advance
  // the model to the state after the coming clock edge.
  task automatic model(input int d, output logic [22:0] e);
    logic tk, hz;
    int   kind;
    logic [1:0] sel;
    tk  = st.jumpMemout | st.jumpOut | (st.branchZout & st.Zout) | (st.branchNout & st.Nout);
    hz  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (BYP[d] == 1 && k == DEPTH - 1) continue;
      if (m_v[d][k] && ((st.idUsesRs && st.idRs == m_rd[d][k]) ||
                        (st.idUsesRt && st.idRt == m_rd[d][k])))
        hz = 1'b1;
    end
    hz  = hz & st.idValid;
    sel = 2'b00;
    if (m_jm[d] > 0) begin
      if (m_jm[d] == 1) begin kind = K_REDIR; sel = 2'b10; m_jm[d] = 0; end
      else begin kind = K_HOLD; m_jm[d] = m_jm[d] - 1; end
    end else if (st.jumpMemout) begin
      if (LAT[d] == 0) begin kind = K_REDIR; sel = 2'b10; end
      else begin kind = K_HOLD; m_jm[d] = LAT[d]; end
    end else if (tk) begin
      kind = K_REDIR; sel = 2'b01;
    end else if (hz) begin
      kind = K_STALL;
    end else begin
      kind = K_NORM;
    end

    case (kind)
      K_STALL: e[22:16] = {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      K_HOLD:  e[22:16] = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      K_REDIR: e[22:16] = {sel,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      default: e[22:16] = {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    endcase
    e[15:0] = 16'(m_cnt[d]);

    if (kind == K_REDIR) begin
      for (int k = 0; k < DEPTH; k++) m_v[d][k] = 1'b0;
      if (m_cnt[d] < 65535) m_cnt[d] = m_cnt[d] + 1;
    end else if (kind != K_HOLD) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        m_v[d][k]  = m_v[d][k-1];
        m_rd[d][k] = m_rd[d][k-1];
      end
      m_v[d][0]  = (kind == K_NORM) && st.idValid && st.idRegWrt;
      m_rd[d][0] = st.idRd;
    end
  endtask

  // Called at a falling edge with st already set; compares, then waits for
  // the next falling edge.
  task automatic step();
    logic [22:0] e;
    #1;
    for (int d = 0; d < 2; d++) begin
      model(d, e);
      obs[d] = outs(d);
      check($sformatf("dut%0d outputs", d), 32'(obs[d]), 32'(e));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    st = '0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("dut%0d reset", d), 32'(outs(d)), 32'(RST_OUTS));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_stim();
    st.branchNout = ($urandom_range(7) == 0);
    st.branchZout = ($urandom_range(7) == 0);
    st.Nout       = $urandom_range(1) == 1;
    st.Zout       = $urandom_range(1) == 1;
    st.jumpOut    = ($urandom_range(15) == 0);
    st.jumpMemout = ($urandom_range(15) == 0);
    st.idValid    = ($urandom_range(3) != 0);
    st.idRs       = 6'($urandom_range(3));
    st.idRt       = 6'($urandom_range(3));
    st.idUsesRs   = $urandom_range(1) == 1;
    st.idUsesRt   = $urandom_range(1) == 1;
    st.idRegWrt   = $urandom_range(1) == 1;
    st.idRd       = 6'($urandom_range(3));
  endtask

  initial begin
    int stalls0, stalls1;
    rst_n = 1'b0;
    st    = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // RAW: writer of r5, then a reader of r5 held in decode
    st = '0; st.idValid = 1; st.idRegWrt = 1; st.idRd = 6'd5;
    step();
    st = '0; st.idValid = 1; st.idUsesRs = 1; st.idRs = 6'd5;
    stalls0 = 0; stalls1 = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!obs[0][20]) stalls0++;
      if (!obs[1][20]) stalls1++;
    end
    check("raw stalls bypass", 32'(stalls0), 32'd1);
    check("raw stalls nobypass", 32'(stalls1), 32'd2);

    // taken / not-taken branch on zero
    st = '0; st.branchZout = 1; st.Zout = 1;
    step();
    check("bz taken sel", 32'(obs[0][22:21]), 32'd1);
    check("bz taken ifidflush", 32'(obs[0][18]), 32'd1);
    st = '0; st.branchZout = 1; st.Zout = 0;
    step();
    check("bz not taken sel", 32'(obs[0][22:21]), 32'd0);
    check("bz count", 32'(obs[0][15:0]), 32'd1);

    // precedence: jumpOut with taken negative branch counts once
    st = '0; st.jumpOut = 1; st.branchNout = 1; st.Nout = 1;
    step();
    check("jo prec sel", 32'(obs[1][22:21]), 32'd1);
    st = '0;
    step();
    check("jo prec count", 32'(obs[1][15:0]), 32'd2);

    // memory jump with a hazard present during the wait
    st = '0; st.idValid = 1; st.idRegWrt = 1; st.idRd = 6'd7;
    step();
    st = '0; st.jumpMemout = 1; st.jumpOut = 1;
    st.idValid = 1; st.idUsesRs = 1; st.idRs = 6'd7;
    step();
    check("jm lat0 sel", 32'(obs[1][22:21]), 32'd2);
    check("jm hold", 32'(obs[0][16]), 32'd1);
    check("jm hold no stall", 32'(obs[0][17]), 32'd0);
    step();
    check("jm wait hold", 32'(obs[0][16]), 32'd1);
    check("jm wait no stall", 32'(obs[0][17]), 32'd0);
    step();
    check("jm redirect sel", 32'(obs[0][22:21]), 32'd2);
    check("jm redirect flush", 32'(obs[0][18]), 32'd1);
    st = '0;
    step();

    // randomized run with periodic resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      rand_stim();
      step();
    end

    // saturation
    do_reset();
    st = '0; st.jumpOut = 1;
    for (int i = 0; i < 65540; i++) step();
    st = '0;
    step();
    check("sat dut0", 32'(obs[0][15:0]), 32'h0000FFFF);
    check("sat dut1", 32'(obs[1][15:0]), 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
